// File: rtl/snake_engine.sv
// snake_engine: snake game-state engine. The body lives in a ring buffer and
// advances one cell per tick after a serial self-collision scan.
`default_nettype none

module snake_engine #(
  parameter int GRID_W   = 40,
  parameter int GRID_H   = 30,
  parameter int X_W      = 6,
  parameter int Y_W      = 5,
  parameter int MAX_LEN  = 64,
  parameter int INIT_LEN = 3,
  parameter int WRAP     = 0,
  parameter int SCORE_W  = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         tick,
  input  logic [2:0]                   dir_in,
  input  logic [X_W-1:0]               food_x,
  input  logic [Y_W-1:0]               food_y,
  input  logic                         food_valid,
  input  logic [X_W-1:0]               query_x,
  input  logic [Y_W-1:0]               query_y,
  output logic                         query_hit,
  output logic                         query_head,
  output logic [X_W-1:0]               head_x,
  output logic [Y_W-1:0]               head_y,
  output logic [$clog2(MAX_LEN+1)-1:0] length,
  output logic [SCORE_W-1:0]           score,
  output logic                         food_eaten,
  output logic                         busy,
  output logic                         game_over
);

  localparam int PW = $clog2(MAX_LEN);
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam logic [2:0] D_UP = 3'd1, D_DOWN = 3'd2, D_LEFT = 3'd3, D_RIGHT = 3'd4;

  typedef enum logic [2:0] {IDLE, STEP, SCAN, COMMIT, DEAD} state_t;

  state_t         state;
  logic [X_W-1:0] body_x [MAX_LEN];
  logic [Y_W-1:0] body_y [MAX_LEN];
  logic [PW-1:0]  head_ptr, tail_ptr;
  logic [2:0]     dir, pending_dir;
  logic [X_W-1:0] next_x, step_x;
  logic [Y_W-1:0] next_y, step_y;
  logic           step_wall, grow;
  logic [LW-1:0]  scan_idx;
  logic [PW-1:0]  scan_ptr;
  logic           scan_hit, scan_last, dir_ok, qhit_c;
  logic [2:0]     dir_ref;

  function automatic logic [2:0] reverse_of(input logic [2:0] d);
    case (d)
      D_UP:    reverse_of = D_DOWN;
      D_DOWN:  reverse_of = D_UP;
      D_LEFT:  reverse_of = D_RIGHT;
      D_RIGHT: reverse_of = D_LEFT;
      default: reverse_of = 3'd0;
    endcase
  endfunction

  // During STEP the pending code is being committed, so reversals are judged
  // against it; otherwise a same-cycle reverse could slip in behind the commit.
  assign dir_ref = (state == STEP) ? pending_dir : dir;
  assign dir_ok  = (dir_in >= D_UP) && (dir_in <= D_RIGHT) && (dir_in != reverse_of(dir_ref));

  always_comb begin
    step_x    = head_x;
    step_y    = head_y;
    step_wall = 1'b0;
    case (pending_dir)
      D_UP:
        if (head_y == '0) begin step_wall = 1'b1; step_y = Y_W'(GRID_H - 1); end
        else step_y = head_y - Y_W'(1);
      D_DOWN:
        if (head_y == Y_W'(GRID_H - 1)) begin step_wall = 1'b1; step_y = '0; end
        else step_y = head_y + Y_W'(1);
      D_LEFT:
        if (head_x == '0) begin step_wall = 1'b1; step_x = X_W'(GRID_W - 1); end
        else step_x = head_x - X_W'(1);
      D_RIGHT:
        if (head_x == X_W'(GRID_W - 1)) begin step_wall = 1'b1; step_x = '0; end
        else step_x = head_x + X_W'(1);
      default: ;
    endcase
  end

  assign scan_ptr  = head_ptr - scan_idx[PW-1:0];
  assign scan_hit  = (body_x[scan_ptr] == next_x) && (body_y[scan_ptr] == next_y);
  assign scan_last = (scan_idx == length - LW'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      dir         <= D_RIGHT;
      pending_dir <= D_RIGHT;
      head_x      <= X_W'(GRID_W / 2);
      head_y      <= Y_W'(GRID_H / 2);
      length      <= LW'(INIT_LEN);
      score       <= '0;
      food_eaten  <= 1'b0;
      busy        <= 1'b0;
      game_over   <= 1'b0;
      head_ptr    <= PW'(INIT_LEN - 1);
      tail_ptr    <= '0;
      scan_idx    <= '0;
      next_x      <= '0;
      next_y      <= '0;
      grow        <= 1'b0;
      for (int i = 0; i < MAX_LEN; i++) begin
        if (i < INIT_LEN) begin
          body_x[i] <= X_W'(GRID_W / 2 - INIT_LEN + 1 + i);
          body_y[i] <= Y_W'(GRID_H / 2);
        end else begin
          body_x[i] <= '0;
          body_y[i] <= '0;
        end
      end
    end else begin
      food_eaten <= 1'b0;
      if (dir_ok) pending_dir <= dir_in;
      case (state)
        IDLE:
          if (tick) begin
            state <= STEP;
            busy  <= 1'b1;
          end
        STEP: begin
          dir      <= pending_dir;
          next_x   <= step_x;
          next_y   <= step_y;
          grow     <= food_valid && (step_x == food_x) && (step_y == food_y);
          scan_idx <= '0;
          if (step_wall && (WRAP == 0)) begin
            state     <= DEAD;
            game_over <= 1'b1;
            busy      <= 1'b0;
          end else begin
            state <= SCAN;
          end
        end
        SCAN:
          // The tail cell vacates this step unless the snake grows.
          if (scan_hit && !(scan_last && !grow)) begin
            state     <= DEAD;
            game_over <= 1'b1;
            busy      <= 1'b0;
          end else if (scan_last) begin
            state <= COMMIT;
          end else begin
            scan_idx <= scan_idx + LW'(1);
          end
        COMMIT: begin
          body_x[head_ptr + PW'(1)] <= next_x;
          body_y[head_ptr + PW'(1)] <= next_y;
          head_ptr <= head_ptr + PW'(1);
          head_x   <= next_x;
          head_y   <= next_y;
          if (grow && (length < LW'(MAX_LEN))) length <= length + LW'(1);
          else tail_ptr <= tail_ptr + PW'(1);
          if (grow) begin
            food_eaten <= 1'b1;
            if (score != '1) score <= score + SCORE_W'(1);
          end
          busy  <= 1'b0;
          state <= IDLE;
        end
        DEAD: ;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    qhit_c = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if ((LW'(PW'(PW'(i) - tail_ptr)) < length) &&
          (body_x[i] == query_x) && (body_y[i] == query_y))
        qhit_c = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      query_hit  <= 1'b0;
      query_head <= 1'b0;
    end else begin
      query_hit  <= qhit_c;
      query_head <= (body_x[head_ptr] == query_x) && (body_y[head_ptr] == query_y);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_snake_engine.sv
// tb_snake_engine: directed table-driven bench for snake_engine (wall and wrap instances).
`default_nettype none

module tb_snake_engine;

  logic       clk = 1'b0;
  logic       rst, tick, food_valid;
  logic [2:0] dir_in;
  logic [5:0] food_x, query_x;
  logic [4:0] food_y, query_y;

  logic       qh0, qhd0, fe0, busy0, go0;
  logic [5:0] hx0;
  logic [4:0] hy0;
  logic [6:0] len0;
  logic [7:0] sc0;
  logic       qh1, qhd1, fe1, busy1, go1;
  logic [5:0] hx1;
  logic [4:0] hy1;
  logic [6:0] len1;
  logic [7:0] sc1;

  snake_engine #(.WRAP(0)) dut0 (
    .clk(clk), .rst(rst), .tick(tick), .dir_in(dir_in),
    .food_x(food_x), .food_y(food_y), .food_valid(food_valid),
    .query_x(query_x), .query_y(query_y), .query_hit(qh0), .query_head(qhd0),
    .head_x(hx0), .head_y(hy0), .length(len0), .score(sc0),
    .food_eaten(fe0), .busy(busy0), .game_over(go0)
  );

  snake_engine #(.WRAP(1)) dut1 (
    .clk(clk), .rst(rst), .tick(tick), .dir_in(dir_in),
    .food_x(food_x), .food_y(food_y), .food_valid(food_valid),
    .query_x(query_x), .query_y(query_y), .query_hit(qh1), .query_head(qhd1),
    .head_x(hx1), .head_y(hy1), .length(len1), .score(sc1),
    .food_eaten(fe1), .busy(busy1), .game_over(go1)
  );

  always #20 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [2:0] d;
    int fx, fy, fv;
    int hx, hy, len, sc, eaten, over, bsy;
  } step_t;

  step_t steps [8];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic do_query(input int qx, input int qy, input int eh, input int ehd);
    @(negedge clk);
    query_x = 6'(qx);
    query_y = 5'(qy);
    @(negedge clk);
    chk($sformatf("hit(%0d,%0d)", qx, qy), int'(qh0), eh);
    chk($sformatf("head(%0d,%0d)", qx, qy), int'(qhd0), ehd);
  endtask

  task automatic do_step(input logic [2:0] d, input int fx, input int fy, input int fv,
                         output int bc, output int ec);
    @(negedge clk);
    dir_in     = d;
    food_x     = 6'(fx);
    food_y     = 5'(fy);
    food_valid = (fv != 0);
    @(negedge clk);
    tick   = 1'b1;
    dir_in = 3'd0;
    @(negedge clk);
    tick = 1'b0;
    bc   = 0;
    ec   = 0;
    while ((busy0 || busy1) && bc < 200) begin
      bc++;
      ec += int'(fe0);
      @(negedge clk);
    end
    ec += int'(fe0);
    @(negedge clk);
    ec += int'(fe0);
    food_valid = 1'b0;
    chk("step_bound", int'(bc < 200), 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int bc, ec;
    rst = 1'b1; tick = 1'b0; dir_in = 3'd0;
    food_x = '0; food_y = '0; food_valid = 1'b0;
    query_x = '0; query_y = '0;

    // dir, food x/y/valid, head x/y, length, score, eaten pulses, game_over, busy cycles
    steps[0] = '{3'd0, 21, 15, 1, 21, 15, 4, 1, 1, 0, 5};  // eat straight ahead
    steps[1] = '{3'd3,  0,  0, 0, 22, 15, 4, 1, 0, 0, 6};  // reverse dropped
    steps[2] = '{3'd1,  0,  0, 0, 22, 14, 4, 1, 0, 0, 6};
    steps[3] = '{3'd3,  0,  0, 0, 21, 14, 4, 1, 0, 0, 6};
    steps[4] = '{3'd2,  0,  0, 0, 21, 15, 4, 1, 0, 0, 6};  // into vacated tail
    steps[5] = '{3'd3, 20, 15, 1, 20, 15, 5, 2, 1, 0, 6};
    steps[6] = '{3'd1,  0,  0, 0, 20, 14, 5, 2, 0, 0, 7};
    steps[7] = '{3'd4,  0,  0, 0, 20, 14, 5, 2, 0, 1, 5};  // turn into own body

    repeat (2) @(negedge clk);
    rst = 1'b0;

    chk("rst_head_x", int'(hx0), 20);
    chk("rst_head_y", int'(hy0), 15);
    chk("rst_length", int'(len0), 3);
    chk("rst_score", int'(sc0), 0);
    chk("rst_busy", int'(busy0), 0);
    chk("rst_over", int'(go0), 0);
    chk("rst_eaten", int'(fe0), 0);
    do_query(18, 15, 1, 0);
    do_query(20, 15, 1, 1);
    do_query(17, 15, 0, 0);
    do_query(21, 15, 0, 0);

    for (int i = 0; i < 8; i++) begin
      do_step(steps[i].d, steps[i].fx, steps[i].fy, steps[i].fv, bc, ec);
      chk($sformatf("s%0d_head_x", i), int'(hx0), steps[i].hx);
      chk($sformatf("s%0d_head_y", i), int'(hy0), steps[i].hy);
      chk($sformatf("s%0d_length", i), int'(len0), steps[i].len);
      chk($sformatf("s%0d_score", i), int'(sc0), steps[i].sc);
      chk($sformatf("s%0d_eaten", i), ec, steps[i].eaten);
      chk($sformatf("s%0d_over", i), int'(go0), steps[i].over);
      chk($sformatf("s%0d_busy", i), bc, steps[i].bsy);
      chk($sformatf("s%0d_wrap_head_x", i), int'(hx1), steps[i].hx);
      if (i == 0) do_query(18, 15, 1, 0);
      if (i == 2) begin
        do_query(19, 15, 0, 0);
        do_query(20, 15, 1, 0);
      end
    end

    // Dead: query still live, ticks ignored.
    do_query(21, 14, 1, 0);
    do_query(20, 14, 1, 1);
    do_step(3'd0, 0, 0, 0, bc, ec);
    chk("dead_busy", bc, 0);
    chk("dead_head_x", int'(hx0), 20);
    chk("dead_head_y", int'(hy0), 14);
    chk("dead_over", int'(go0), 1);

    do_reset();
    chk("clr_over", int'(go0), 0);
    chk("clr_head_x", int'(hx0), 20);
    chk("clr_length", int'(len0), 3);

    repeat (19) do_step(3'd0, 0, 0, 0, bc, ec);
    chk("edge_head_x", int'(hx0), 39);
    chk("edge_wrap_head_x", int'(hx1), 39);
    chk("edge_over", int'(go0), 0);

    do_step(3'd0, 0, 0, 0, bc, ec);
    chk("wall_over", int'(go0), 1);
    chk("wall_head_x", int'(hx0), 39);
    chk("wrap_over", int'(go1), 0);
    chk("wrap_head_x", int'(hx1), 0);
    chk("wrap_head_y", int'(hy1), 15);

    do_step(3'd0, 0, 0, 0, bc, ec);
    chk("wall_frozen_x", int'(hx0), 39);
    chk("wall_still_over", int'(go0), 1);
    chk("wrap_next_x", int'(hx1), 1);

    // Reset in the middle of a scan.
    @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    @(negedge clk);
    chk("midscan_busy", int'(busy1), 1);
    do_reset();
    chk("midrst_busy", int'(busy1), 0);
    chk("midrst_head_x", int'(hx1), 20);
    chk("midrst_over", int'(go0), 0);
    chk("midrst_head0_x", int'(hx0), 20);
    repeat (6) @(negedge clk);
    chk("midrst_hold_x", int'(hx1), 20);
    chk("midrst_hold_busy", int'(busy1), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/snake_engine.md
Name: snake_engine

Overview:
- Parametrised snake game-state engine. Holds the snake body in a ring buffer and advances it one cell per animate tick.
- Enforces direction rules, food growth, wall/wrap and self-collision, and score.
- Sits between the keyboard movement decoder and the VGA pixel renderer. Score feeds the seven-segment driver.
- Generalises the fixed-size snake logic to arbitrary grid, maximum length, and wall-or-wrap mode.

Parameters:
- GRID_W, 40, grid columns.
- GRID_H, 30, grid rows.
- X_W, 6, bits for a column index.
- Y_W, 5, bits for a row index.
- MAX_LEN, 64, body capacity in segments (power of two).
- INIT_LEN, 3, length after reset (2..MAX_LEN).
- WRAP, 0. 0 = hitting a wall ends the game. 1 = head wraps to the opposite edge.
- SCORE_W, 8, score counter width.

Ports:
- clk, in, 1: the single clock; the 25 MHz pixel clock.
- rst, in, 1: synchronous, active-high reset.
- tick, in, 1: one-cycle step strobe (vga animate).
- dir_in, in, 3: movement code. 0 none, 1 up, 2 down, 3 left, 4 right; 5-7 are treated as none.
- food_x, in, X_W: food column.
- food_y, in, Y_W: food row.
- food_valid, in, 1: food position is live.
- query_x, in, X_W: pixel cell column for lookup.
- query_y, in, Y_W: pixel cell row for lookup.
- query_hit, out, 1: queried cell holds a body segment.
- query_head, out, 1: queried cell is the head.
- head_x, out, X_W: current head column.
- head_y, out, Y_W: current head row.
- length, out, $clog2(MAX_LEN+1): current segment count.
- score, out, SCORE_W: food eaten.
- food_eaten, out, 1: one-cycle pulse on growth.
- busy, out, 1: step in progress.
- game_over, out, 1: sticky until rst.

Behaviour:
- Reset state (all outputs after one clk with rst high):
  - Head at (GRID_W/2, GRID_H/2).
  - Body occupies INIT_LEN cells extending leftward from the head.
  - Direction = right; length = INIT_LEN; score = 0.
  - food_eaten = 0, busy = 0, game_over = 0, FSM in IDLE.
  - rst overrides any state, including mid-scan.
- Direction latch:
  - Every cycle, a nonzero dir_in is written to pending_dir, unless it is the exact reverse of the committed direction.
  - Reversals are dropped; the last legal code wins.
  - pending_dir becomes the committed direction at STEP.
- FSM states: IDLE, STEP, SCAN, COMMIT, DEAD.
- IDLE: on tick go to STEP. While busy or DEAD, tick is ignored (not queued).
- STEP (1 cycle):
  - Compute next head = head ± 1 on the committed axis.
  - WRAP=0: next head outside 0..GRID_W-1 or 0..GRID_H-1 → DEAD, game_over = 1.
  - WRAP=1: step past the edge wraps to the opposite edge (−1 → max, max+1 → 0).
  - Compute grow = food_valid && next head == food.
  - Clear the scan index and go to SCAN.
- SCAN (one segment per cycle):
  - Compare next head with body segments from the head toward the tail.
  - If not growing, the tail segment is excluded, because it vacates this step.
  - On any match → DEAD, game_over = 1.
  - After the last segment → COMMIT.
- COMMIT (1 cycle):
  - Write next head at head_ptr+1 (mod MAX_LEN) and advance head_ptr.
  - If grow and length < MAX_LEN: length += 1 and the tail stays put.
  - Otherwise the tail pointer advances.
  - If grow: score += 1, saturating at 2^SCORE_W−1. This holds even when length is saturated at MAX_LEN.
  - If grow: food_eaten = 1 for exactly this cycle.
  - Return to IDLE.
- Step latency: tick to updated head = length + 2 cycles. busy is high from STEP through COMMIT inclusive.
- DEAD: head, body and score frozen; query still works; only rst exits.
- Query path:
  - Parallel compare of (query_x, query_y) against every live segment, registered.
  - Latency 1 cycle. query_head is set only for the head segment.
  - Query results reflect the body before COMMIT until the cycle after COMMIT.

Test Plan:
- Reset with defaults → head (20,15), length 3, query (18,15) gives hit=1 after 1 cycle, query (17,15) gives hit=0, score 0.
- dir_in=1 held, then tick → busy for 5 cycles, head (20,14), query (18,15) gives hit=0.
- Heading right, dir_in=3 (reverse), tick → head (21,15), direction unchanged.
- food (21,15) valid, tick → food_eaten pulses 1 cycle, length 4, score 1, tail cell (18,15) still hit.
- WRAP=0, head driven to (39,y) going right, tick → game_over=1; later ticks leave the head unchanged; rst clears it.
- WRAP=1, same case → head (0,y), game_over=0.
- Length 5, turn sequence up/left/down into the body → game_over=1 during SCAN.
- Moving into the cell the tail just vacated (non-growing) → no game over.
